// File: rtl/alarm_ctrl.sv
// Alarm controller for the 12-hour clock: programmable alarm time, one-hot
// IDLE/ARMED/RINGING/SNOOZE FSM, ring timeout and bounded snooze count.
// Optional build macro: ALARM_BEEP_EN (ring toggles on each en strobe while ringing).
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [3:0]                        hour,
    input  logic [5:0]                        min,
    input  logic [5:0]                        sec,
    input  logic                              pm,
    input  logic                              set_valid,
    input  logic [3:0]                        set_hour,
    input  logic [5:0]                        set_min,
    input  logic                              set_pm,
    input  logic                              arm,
    input  logic                              disarm,
    input  logic                              stop,
    input  logic                              snooze,
    output logic                              ring,
    output logic [3:0]                        state,
    output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_cnt,
    output logic                              set_err
);

    localparam int SCW = $clog2(MAX_SNOOZE + 1);
    localparam int RCW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam int ZCW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;

    localparam logic [RCW-1:0] RING_LAST = RCW'(RING_SECS - 1);
    localparam logic [ZCW-1:0] SNZ_LAST  = ZCW'(SNOOZE_SECS - 1);
    localparam logic [SCW-1:0] SNZ_MAX   = SCW'(MAX_SNOOZE);

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_ARMED   = 4'b0010,
        S_RINGING = 4'b0100,
        S_SNOOZE  = 4'b1000
    } state_e;

    state_e         state_q,      state_d;
    logic           ring_q,       ring_d;
    logic [SCW-1:0] snooze_cnt_q, snooze_cnt_d;
    logic           set_err_q,    set_err_d;
    logic [RCW-1:0] ring_cnt_q,   ring_cnt_d;
    logic [ZCW-1:0] snz_cnt_q,    snz_cnt_d;
    logic [3:0]     alm_hour_q,   alm_hour_d;
    logic [5:0]     alm_min_q,    alm_min_d;
    logic           alm_pm_q,     alm_pm_d;
    logic           match_dly_q,  match_dly_d;

    logic set_ok;
    logic match;
    logic trigger;

    assign set_ok  = set_valid && (set_hour >= 4'd1) && (set_hour <= 4'd12) && (set_min <= 6'd59);
    assign match   = (hour == alm_hour_q) && (min == alm_min_q) && (pm == alm_pm_q) && (sec == 6'd0);
    // Rising edge only, so a held hh:mm:00 cannot re-trigger after stop, auto-off or re-arm.
    assign trigger = match && !match_dly_q;

    always_comb begin
        // NOTE: every _d signal gets its hold value first so no path can infer a latch.
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snz_cnt_d    = snz_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        alm_hour_d   = alm_hour_q;
        alm_min_d    = alm_min_q;
        alm_pm_d     = alm_pm_q;
        set_err_d    = set_valid && !set_ok;
        match_dly_d  = match;

        if (set_ok) begin
            alm_hour_d = set_hour;
            alm_min_d  = set_min;
            alm_pm_d   = set_pm;
        end

        if (disarm) begin
            state_d      = S_IDLE;
            snooze_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trigger && !set_ok) begin
                        state_d    = S_RINGING;
                        ring_cnt_d = '0;
                    end
                end
                S_RINGING: begin
                    if (set_ok || stop) begin
                        state_d      = S_ARMED;
                        snooze_cnt_d = '0;
                    end else if (snooze && (snooze_cnt_q < SNZ_MAX)) begin
                        state_d      = S_SNOOZE;
                        snz_cnt_d    = '0;
                        snooze_cnt_d = snooze_cnt_q + 1'b1;
                    end else if (en) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d      = S_ARMED;
                            snooze_cnt_d = '0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 1'b1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (set_ok || stop) begin
                        state_d      = S_ARMED;
                        snooze_cnt_d = '0;
                    end else if (en) begin
                        if (snz_cnt_q == SNZ_LAST) begin
                            state_d    = S_RINGING;
                            ring_cnt_d = '0;
                        end else begin
                            snz_cnt_d = snz_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    snooze_cnt_d = '0;
                end
            endcase
        end
    end

`ifdef ALARM_BEEP_EN
    always_comb begin
        ring_d = 1'b0;
        if (state_d == S_RINGING) begin
            if (state_q != S_RINGING) begin
                ring_d = 1'b1;
            end else if (en) begin
                ring_d = !ring_q;
            end else begin
                ring_d = ring_q;
            end
        end
    end
`else
    always_comb begin
        ring_d = (state_d == S_RINGING);
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            ring_q       <= 1'b0;
            snooze_cnt_q <= '0;
            set_err_q    <= 1'b0;
            ring_cnt_q   <= '0;
            snz_cnt_q    <= '0;
            alm_hour_q   <= 4'd12;
            alm_min_q    <= 6'd0;
            alm_pm_q     <= 1'b0;
            match_dly_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_q       <= ring_d;
            snooze_cnt_q <= snooze_cnt_d;
            set_err_q    <= set_err_d;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            alm_hour_q   <= alm_hour_d;
            alm_min_q    <= alm_min_d;
            alm_pm_q     <= alm_pm_d;
            match_dly_q  <= match_dly_d;
        end
    end

    assign ring       = ring_q;
    assign state      = state_q;
    assign snooze_cnt = snooze_cnt_q;
    assign set_err    = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: a cycle model pushes expected outputs per driven
// cycle, popped and compared after each edge; directed checks cover the key scenarios.
module tb_alarm_ctrl;

    localparam int RING_SECS   = 5;
    localparam int SNOOZE_SECS = 3;
    localparam int MAX_SNOOZE  = 2;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_ARMED = 4'b0010;
    localparam logic [3:0] ST_RING  = 4'b0100;
    localparam logic [3:0] ST_SNZ   = 4'b1000;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] hour;
    logic [5:0] min, sec;
    logic       pm;
    logic       set_valid;
    logic [3:0] set_hour;
    logic [5:0] set_min;
    logic       set_pm;
    logic       arm, disarm, stop, snooze;
    logic       ring;
    logic [3:0] state;
    logic [1:0] snooze_cnt;
    logic       set_err;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .pm        (pm),
        .set_valid (set_valid),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_pm    (set_pm),
        .arm       (arm),
        .disarm    (disarm),
        .stop      (stop),
        .snooze    (snooze),
        .ring      (ring),
        .state     (state),
        .snooze_cnt(snooze_cnt),
        .set_err   (set_err)
    );

    typedef struct {
        logic [3:0] st;
        logic       rg;
        logic [1:0] sc;
        logic       er;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state.
    logic [3:0] m_state = ST_IDLE;
    logic       m_ring  = 1'b0;
    logic       m_err   = 1'b0;
    logic       m_ap    = 1'b0;
    logic       m_md    = 1'b0;
    int         m_scnt  = 0;
    int         m_rc    = 0;
    int         m_zc    = 0;
    int         m_ah    = 12;
    int         m_am    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(output exp_t e);
        bit ok, match, trig, was_ring;
        ok       = set_valid && (set_hour >= 1) && (set_hour <= 12) && (set_min <= 59);
        match    = (hour == m_ah) && (min == m_am) && (pm == m_ap) && (sec == 0);
        trig     = match && !m_md;
        was_ring = (m_state == ST_RING);
        if (rst) begin
            m_state = ST_IDLE; m_err = 0; m_md = 0; m_scnt = 0; m_rc = 0; m_zc = 0;
            m_ah = 12; m_am = 0; m_ap = 0;
        end else begin
            m_err = set_valid && !ok;
            m_md  = match;
            if (disarm) begin
                m_state = ST_IDLE; m_scnt = 0;
            end else if (ok && (m_state == ST_RING || m_state == ST_SNZ)) begin
                m_state = ST_ARMED; m_scnt = 0;
            end else if (m_state == ST_IDLE) begin
                if (arm) m_state = ST_ARMED;
            end else if (ok) begin
            end else if (m_state == ST_ARMED) begin
                if (trig) begin m_state = ST_RING; m_rc = 0; end
            end else if (stop) begin
                m_state = ST_ARMED; m_scnt = 0;
            end else if (m_state == ST_RING && snooze && m_scnt < MAX_SNOOZE) begin
                m_state = ST_SNZ; m_zc = 0; m_scnt++;
            end else if (en) begin
                if (m_state == ST_RING) begin
                    m_rc++;
                    if (m_rc == RING_SECS) begin m_state = ST_ARMED; m_scnt = 0; end
                end else begin
                    m_zc++;
                    if (m_zc == SNOOZE_SECS) begin m_state = ST_RING; m_rc = 0; end
                end
            end
            if (ok) begin m_ah = set_hour; m_am = set_min; m_ap = set_pm; end
        end
`ifdef ALARM_BEEP_EN
        if (m_state != ST_RING) m_ring = 0;
        else if (!was_ring)     m_ring = 1;
        else if (en)            m_ring = !m_ring;
`else
        m_ring = (m_state == ST_RING);
`endif
        e.st = m_state;
        e.rg = m_ring;
        e.sc = 2'(m_scnt);
        e.er = m_err;
    endtask

    task automatic advance_time();
        if (sec == 59) begin
            sec = 0;
            if (min == 59) begin
                min = 0;
                if (hour == 11)      begin hour = 12; pm = ~pm; end
                else if (hour == 12) hour = 1;
                else                 hour = hour + 4'd1;
            end else begin
                min = min + 6'd1;
            end
        end else begin
            sec = sec + 6'd1;
        end
    endtask

    task automatic tick();
        exp_t e, g;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (en) advance_time();
        set_valid = 0; arm = 0; disarm = 0; stop = 0; snooze = 0;
        g = sb_q.pop_front();
        check("sb_state", state, g.st);
        check("sb_ring", ring, g.rg);
        check("sb_snooze_cnt", snooze_cnt, g.sc);
        check("sb_set_err", set_err, g.er);
    endtask

    task automatic set_time(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s, input logic p);
        hour = h; min = m; sec = s; pm = p;
    endtask

    task automatic set_alarm(input logic [3:0] h, input logic [5:0] m, input logic p);
        set_valid = 1; set_hour = h; set_min = m; set_pm = p;
        tick();
    endtask

    task automatic run_until(input logic [3:0] h, input logic [5:0] m, input logic p, input string tag);
        bit reached;
        for (int i = 0; i < 400 && !(hour == h && min == m && sec == 0 && pm == p); i++) tick();
        reached = (hour == h && min == m && sec == 0 && pm == p);
        check(tag, reached, 1);
    endtask

    initial begin
        logic [3:0] bad_h [3];
        logic [5:0] bad_m [3];
        bad_h[0] = 4'd0;  bad_m[0] = 6'd4;
        bad_h[1] = 4'd13; bad_m[1] = 6'd4;
        bad_h[2] = 4'd12; bad_m[2] = 6'd60;

        rst = 1; en = 1;
        set_valid = 0; set_hour = 0; set_min = 0; set_pm = 0;
        arm = 0; disarm = 0; stop = 0; snooze = 0;
        set_time(12, 0, 0, 0);
        tick(); tick();
        check("rst_state", state, ST_IDLE);
        check("rst_ring", ring, 0);
        check("rst_snooze_cnt", snooze_cnt, 0);
        check("rst_set_err", set_err, 0);
        rst = 0;

        // Set, arm, trigger, auto-off.
        set_time(12, 0, 0, 0);
        set_alarm(12, 1, 0);
        check("t1_set_no_err", set_err, 0);
        arm = 1; tick();
        check("t1_armed", state, ST_ARMED);
        run_until(12, 1, 0, "t1_reach_12_01");
        tick();
        check("t1_ring_rise", ring, 1);
        check("t1_state_ringing", state, ST_RING);
        repeat (4) tick();
        check("t1_ring_hold", ring, 1);
        tick();
        check("t1_auto_off_state", state, ST_ARMED);
        check("t1_auto_off_ring", ring, 0);

        // Snooze limit.
        set_alarm(12, 3, 0);
        run_until(12, 3, 0, "t2_reach_12_03");
        tick();
        check("t2_ring_rise", ring, 1);
        snooze = 1; tick();
        check("t2_snz1_state", state, ST_SNZ);
        check("t2_snz1_cnt", snooze_cnt, 1);
        check("t2_snz1_ring", ring, 0);
        repeat (2) tick();
        check("t2_snz1_hold", state, ST_SNZ);
        tick();
        check("t2_resume_state", state, ST_RING);
        check("t2_resume_cnt", snooze_cnt, 1);
        check("t2_resume_ring", ring, 1);
        snooze = 1; tick();
        check("t2_snz2_state", state, ST_SNZ);
        check("t2_snz2_cnt", snooze_cnt, 2);
        repeat (3) tick();
        check("t2_resume2_state", state, ST_RING);
        snooze = 1; tick();
        check("t2_snz3_ignored", state, ST_RING);
        check("t2_snz3_cnt", snooze_cnt, 2);
        repeat (3) tick();
        check("t2_still_ringing", state, ST_RING);
        tick();
        check("t2_auto_off_state", state, ST_ARMED);
        check("t2_auto_off_cnt", snooze_cnt, 0);

        // Set rejection; a wrongly loaded alarm would miss the 12:04 trigger below.
        set_alarm(12, 4, 0);
        for (int i = 0; i < 3; i++) begin
            set_alarm(bad_h[i], bad_m[i], 0);
            check("t4_set_err_pulse", set_err, 1);
            tick();
            check("t4_set_err_clear", set_err, 0);
        end

        // Stop and no retrigger while the second is held at :00.
        run_until(12, 4, 0, "t3_reach_12_04");
        en = 0;
        tick();
        check("t3_ring_rise", ring, 1);
        stop = 1; tick();
        check("t3_stop_state", state, ST_ARMED);
        check("t3_stop_ring", ring, 0);
        repeat (3) begin
            tick();
            check("t3_no_retrigger", ring, 0);
        end
        disarm = 1; tick();
        check("t3_disarm_state", state, ST_IDLE);
        arm = 1; tick();
        check("t3_rearm_state", state, ST_ARMED);
        tick();
        check("t3_rearm_no_ring", ring, 0);
        en = 1;

        // Priority: disarm beats stop and snooze.
        set_alarm(12, 5, 0);
        run_until(12, 5, 0, "t5_reach_12_05");
        tick();
        check("t5_ring_rise", ring, 1);
        disarm = 1; stop = 1; snooze = 1; tick();
        check("t5_prio_state", state, ST_IDLE);
        check("t5_prio_ring", ring, 0);

        // Reset mid-snooze, then prove the alarm time returned to 12:00 AM.
        set_alarm(12, 6, 0);
        arm = 1; tick();
        run_until(12, 6, 0, "t6_reach_12_06");
        tick();
        snooze = 1; tick();
        check("t6_snoozing", state, ST_SNZ);
        rst = 1; tick(); tick(); rst = 0;
        check("t6_rst_state", state, ST_IDLE);
        check("t6_rst_ring", ring, 0);
        check("t6_rst_cnt", snooze_cnt, 0);
        set_time(11, 59, 57, 1);
        arm = 1; tick();
        run_until(12, 0, 0, "t6_reach_midnight");
        tick();
        check("t6_default_alarm_ring", ring, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm controller that consumes the time outputs of the 12-hour clock (`twelve_hr_clock`) and drives the alarm indicator. It holds a programmable alarm time and a one-hot FSM with four states: disarmed, armed, ringing and snoozing. It detects a hh:mm:00 match against the running clock and handles ring timeout and a bounded number of snoozes. Time is counted in one-second strobes, using the same enable that advances the clock.

## Interface
- `RING_SECS`, 60: seconds (en strobes) the alarm rings before auto-off.
- `SNOOZE_SECS`, 300: snooze length in en strobes.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: one-second strobe; the same signal that advances the clock.
- `hour` in 4: current hour, 1..12.
- `min` in 6: current minute, 0..59.
- `sec` in 6: current second, 0..59.
- `pm` in 1: current meridiem.
- `set_valid` in 1: load alarm time, single-cycle.
- `set_hour` in 4, `set_min` in 6, `set_pm` in 1: alarm time to load.
- `arm` in 1: pulse that moves IDLE to ARMED.
- `disarm` in 1: pulse that forces IDLE.
- `stop` in 1: pulse that silences the ring.
- `snooze` in 1: pulse that requests a snooze.
- `ring` out 1: alarm sounding.
- `state` out 4: one-hot state, {SNOOZE, RINGING, ARMED, IDLE}.
- `snooze_cnt` out 2+: snoozes used; width is `$clog2(MAX_SNOOZE+1)`.
- `set_err` out 1: one-cycle pulse when a set request is rejected.

## Operation
- Alarm register: `alm_hour`, `alm_min`, `alm_pm`. Reset value is 12:00 AM (12, 0, 0).
- `set_valid` with `set_hour` in 1..12 and `set_min` ≤ 59:
  - Loads the register in any state.
  - In RINGING or SNOOZE it also forces ARMED and clears `snooze_cnt`.
- Out-of-range values: the register is unchanged and `set_err`=1 for one cycle.
- match = (hour==alm_hour) && (min==alm_min) && (pm==alm_pm) && (sec==0).
- `match_d` is the registered previous value of match (reset 0). trigger = match && !match_d.
- Transitions, priority highest first:
  - `rst`
  - `disarm`: any state → IDLE.
  - `set_valid` (valid values)
  - `stop`
  - `snooze`
  - trigger / timers
- IDLE: `arm` → ARMED. The alarm register and `match_d` keep updating.
- ARMED:
  - trigger → RINGING; ring counter cleared.
  - `arm` is ignored.
- RINGING:
  - `stop` → ARMED; `snooze_cnt` cleared.
  - `snooze` with `snooze_cnt` < MAX_SNOOZE → SNOOZE; snooze counter cleared; `snooze_cnt`+1.
  - `snooze` with `snooze_cnt` == MAX_SNOOZE is ignored.
  - Each `en` increments the ring counter. `en` with ring counter == RING_SECS-1 → ARMED; `snooze_cnt` cleared.
- SNOOZE:
  - `stop` → ARMED; `snooze_cnt` cleared.
  - Each `en` increments the snooze counter. `en` with snooze counter == SNOOZE_SECS-1 → RINGING; ring counter cleared.
- Edge detection stops re-triggering within the matching second. The cases it covers:
  - after `stop`;
  - after auto-off;
  - after arming while match is already 1.
- `state` is always exactly one-hot. An illegal encoding recovers to IDLE on the next cycle.

## Timing
- Reset values:
  - `state`=4'b0001 (IDLE), `ring`=0, `snooze_cnt`=0, `set_err`=0.
  - Counters 0; alarm 12:00 AM; `match_d`=0.
- All outputs are registered.
- `ring` rises 1 cycle after the cycle on which trigger is true.
- `ring`=1 only while `state`=RINGING.
- Control pulses take effect on the next edge; `state` reflects them 1 cycle later.
- Ring duration is exactly RING_SECS `en` strobes. Snooze duration is exactly SNOOZE_SECS `en` strobes.
- Simultaneous `stop` and `snooze`: `stop` wins.
- Simultaneous `en` timeout and `stop`: `stop` wins; the end state is ARMED either way.
- `rst` mid-ring: everything returns to reset values on the next edge, including the alarm time.

## Configuration
- `ALARM_BEEP_EN` defined:
  - In RINGING, `ring` toggles on every `en` strobe (1 s on / 1 s off).
  - It starts high on entry to RINGING.
- `ALARM_BEEP_EN` undefined: `ring` is held steady high throughout RINGING.
- The FSM and counters are identical in both builds.

## Test plan
Bench parameters: RING_SECS=5, SNOOZE_SECS=3, MAX_SNOOZE=2; `en` every cycle.

- **Set, arm, trigger:** set 12:01 AM, arm, clock runs from reset → `ring`=1 one cycle after the clock shows 12:1:0 AM; 5 strobes later, `state`=ARMED and `ring`=0.
- **Snooze limit:** trigger, then `snooze` → SNOOZE for 3 strobes, then RINGING, `snooze_cnt`=1. Snooze again → `snooze_cnt`=2. Third `snooze` ignored; auto-off to ARMED, `snooze_cnt`=0.
- **Stop and no retrigger:** `stop` 1 cycle after trigger, still at sec=0 → ARMED; `ring` stays 0 for the rest of that second.
- **Set rejection:** `set_hour`=0 or 13, or `set_min`=60 → `set_err` pulse of 1 cycle; alarm time unchanged.
- **Priority:** `disarm`+`stop`+`snooze` in the same cycle while RINGING → IDLE.
- **Reset mid-snooze:** `rst` for 2 cycles → `state`=0001, `ring`=0, `snooze_cnt`=0, alarm 12:00 AM.
